// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage -- instruction decode stage with load-use hazard detection.
//
// Splits a 32-bit instruction into opcode and three 9-bit fields, forms the
// register indices and sign-extended immediate for R-type and I-type words,
// and registers them toward the ID/EX register. A one-entry tracker remembers
// the destination of a load issued in the previous cycle. When the current
// instruction reads that register, one bubble is inserted (STALL state) and
// the held instruction is issued on the following cycle.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous reset, active-low
//   Instr      in   32-bit instruction word from fetch
//   InValid    in   Instr is valid this cycle
//   InReady    out  combinational; Instr is accepted this cycle
//   Flush      in   branch-taken kill from EX; forces a bubble
//   OutValid   out  registered; decoded fields are valid
//   OpCode     out  registered 5-bit opcode
//   Rd/Rs/Rt   out  registered 9-bit register indices
//   Rsi        out  registered 20-bit sign-extended immediate
//   StallCount out  registered, saturating count of load-use bubbles
// ----------------------------------------------------------------------------
module id_stage #(
    parameter logic [4:0] LOAD_OP = 5'd20,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Instr,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Flush,
    output logic             OutValid,
    output logic [4:0]       OpCode,
    output logic [8:0]       Rd,
    output logic [8:0]       Rs,
    output logic [8:0]       Rt,
    output logic [19:0]      Rsi,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    logic       ld_valid;
    logic [8:0] ld_rd;

    logic [4:0]  dec_op;
    logic [8:0]  dec_rd;
    logic [8:0]  dec_rs;
    logic [8:0]  dec_rt;
    logic [19:0] dec_rsi;
    logic        is_rtype;
    logic        hazard;
    logic        accept;

    // Field decode of the word currently presented by fetch.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_op   = Instr[31:27];
        is_rtype = ~Instr[31];
        dec_rd   = Instr[26:18];
        dec_rs   = Instr[17:9];
        dec_rt   = Instr[8:0];
        dec_rsi  = '0;
        if (!is_rtype) begin
            dec_rs  = Instr[26:18];
            dec_rt  = '0;
            dec_rsi = {{2{Instr[17]}}, Instr[17:0]};
        end
    end

    // Index 0 is the hard-wired zero register and never creates a hazard.
    // Only R-type words actually read Rt; I-type bits 8:0 are immediate.
    always_comb begin
        hazard = 1'b0;
        if (state == RUN && InValid && ld_valid && ld_rd != 9'd0) begin
            hazard = (dec_rs == ld_rd) || (is_rtype && dec_rt == ld_rd);
        end
    end

    // In STALL the hazard term is already zero, so the held word is taken.
    assign InReady = rst && !Flush && !hazard;
    assign accept  = InValid && InReady;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: reset is sampled on the clock edge; it clears all state and wins
    // over Flush and any stall in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            ld_valid   <= 1'b0;
            ld_rd      <= '0;
            OutValid   <= 1'b0;
            OpCode     <= '0;
            Rd         <= '0;
            Rs         <= '0;
            Rt         <= '0;
            Rsi        <= '0;
            StallCount <= '0;
        end else begin
            // Default: bubble with empty tracker; overridden on accept.
            OutValid <= 1'b0;
            OpCode   <= '0;
            Rd       <= '0;
            Rs       <= '0;
            Rt       <= '0;
            Rsi      <= '0;
            ld_valid <= 1'b0;

            if (Flush) begin
                state <= RUN;
            end else if (hazard) begin
                state <= STALL;
                if (StallCount != '1) begin
                    StallCount <= StallCount + CNT_ONE;
                end
            end else if (accept) begin
                state    <= RUN;
                OutValid <= 1'b1;
                OpCode   <= dec_op;
                Rd       <= dec_rd;
                Rs       <= dec_rs;
                Rt       <= dec_rt;
                Rsi      <= dec_rsi;
                ld_valid <= (dec_op == LOAD_OP);
                ld_rd    <= dec_rd;
            end else begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// ----------------------------------------------------------------------------
// tb_id_stage -- directed bench for id_stage.
//
// Two instances share one stimulus stream: dut_a with the default 16-bit
// stall counter and dut_b built with CNT_W=2 to reach counter saturation.
// Inputs change 1 time unit after a rising edge; InReady is sampled 1 unit
// after the inputs settle and registered outputs 1 unit after the edge.
// ----------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] Instr;
    logic        InValid;
    logic        Flush;

    logic        a_ready, a_ovalid;
    logic [4:0]  a_op;
    logic [8:0]  a_rd, a_rs, a_rt;
    logic [19:0] a_rsi;
    logic [15:0] a_cnt;

    logic        b_ready, b_ovalid;
    logic [4:0]  b_op;
    logic [8:0]  b_rd, b_rs, b_rt;
    logic [19:0] b_rsi;
    logic [1:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    id_stage dut_a (
        .clk(clk), .rst(rst), .Instr(Instr), .InValid(InValid),
        .InReady(a_ready), .Flush(Flush), .OutValid(a_ovalid),
        .OpCode(a_op), .Rd(a_rd), .Rs(a_rs), .Rt(a_rt), .Rsi(a_rsi),
        .StallCount(a_cnt)
    );

    id_stage #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .Instr(Instr), .InValid(InValid),
        .InReady(b_ready), .Flush(Flush), .OutValid(b_ovalid),
        .OpCode(b_op), .Rd(b_rd), .Rs(b_rs), .Rt(b_rt), .Rsi(b_rsi),
        .StallCount(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_fields(input string tag, input logic ov,
                                input logic [4:0] op, input logic [8:0] rd,
                                input logic [8:0] rs, input logic [8:0] rt,
                                input logic [19:0] rsi);
        check({tag, ".ovalid"}, 32'(a_ovalid), 32'(ov));
        check({tag, ".op"},     32'(a_op),     32'(op));
        check({tag, ".rd"},     32'(a_rd),     32'(rd));
        check({tag, ".rs"},     32'(a_rs),     32'(rs));
        check({tag, ".rt"},     32'(a_rt),     32'(rt));
        check({tag, ".rsi"},    32'(a_rsi),    32'(rsi));
    endtask

    initial begin
        rst = 1'b0; Instr = '0; InValid = 1'b0; Flush = 1'b0;

        // Reset state, InReady low while in reset.
        tick(); tick();
        check("rst.ready_a", 32'(a_ready), 32'd0);
        check("rst.ready_b", 32'(b_ready), 32'd0);
        check_fields("rst", 1'b0, 5'd0, 9'd0, 9'd0, 9'd0, 20'd0);
        check("rst.cnt", 32'(a_cnt), 32'd0);

        // R-type decode.
        rst = 1'b1;
        Instr = {5'd3, 9'd1, 9'd2, 9'd3}; InValid = 1'b1;
        settle();
        check("rtype.ready", 32'(a_ready), 32'd1);
        tick();
        check_fields("rtype", 1'b1, 5'd3, 9'd1, 9'd2, 9'd3, 20'd0);

        // I-type decode with negative immediate.
        Instr = {5'd17, 9'd6, 18'h3FFF0};
        tick();
        check_fields("itype", 1'b1, 5'd17, 9'd6, 9'd6, 9'd0, 20'hFFFF0);

        // Load to r9, then R-type reading r9 through Rs: one bubble.
        Instr = {5'd20, 9'd9, 18'h00005};
        tick();
        check_fields("load9", 1'b1, 5'd20, 9'd9, 9'd9, 9'd0, 20'h00005);
        Instr = {5'd3, 9'd4, 9'd9, 9'd5};
        settle();
        check("lu.ready_lo", 32'(a_ready), 32'd0);
        tick();
        check_fields("lu.bubble", 1'b0, 5'd0, 9'd0, 9'd0, 9'd0, 20'd0);
        check("lu.cnt", 32'(a_cnt), 32'd1);
        check("lu.ready_stall", 32'(a_ready), 32'd1);
        tick();
        check_fields("lu.issue", 1'b1, 5'd3, 9'd4, 9'd9, 9'd5, 20'd0);
        check("lu.cnt_hold", 32'(a_cnt), 32'd1);

        // Load to r0 never hazards.
        Instr = {5'd20, 9'd0, 18'd0};
        tick();
        Instr = {5'd2, 9'd7, 9'd0, 9'd0};
        settle();
        check("r0.ready", 32'(a_ready), 32'd1);
        tick();
        check("r0.ovalid", 32'(a_ovalid), 32'd1);
        check("r0.cnt", 32'(a_cnt), 32'd1);

        // Load r9, R-type reading r9 through Rt stalls; Flush during STALL.
        Instr = {5'd20, 9'd9, 18'd0};
        tick();
        Instr = {5'd3, 9'd1, 9'd2, 9'd9};
        settle();
        check("rt.ready_lo", 32'(a_ready), 32'd0);
        tick();
        check("rt.cnt", 32'(a_cnt), 32'd2);
        Flush = 1'b1;
        settle();
        check("fl.ready_lo", 32'(a_ready), 32'd0);
        tick();
        check("fl.ovalid", 32'(a_ovalid), 32'd0);
        check("fl.cnt", 32'(a_cnt), 32'd2);
        Flush = 1'b0;
        settle();
        check("fl.reissue_ready", 32'(a_ready), 32'd1);
        tick();
        check_fields("fl.reissue", 1'b1, 5'd3, 9'd1, 9'd2, 9'd9, 20'd0);
        check("fl.cnt_hold", 32'(a_cnt), 32'd2);

        // Back-to-back loads to r9: I-type reads f1, so the second hazards.
        Instr = {5'd20, 9'd9, 18'd0};
        tick();
        settle();
        check("ll.ready_lo", 32'(a_ready), 32'd0);
        tick();
        check("ll.cnt_a", 32'(a_cnt), 32'd3);
        check("ll.cnt_b", 32'(b_cnt), 32'd3);
        tick();
        check("ll.issue", 32'(a_ovalid), 32'd1);
        // Same held load hazards again on its own predecessor: fourth bubble.
        tick();
        check("sat.cnt_a", 32'(a_cnt), 32'd4);
        check("sat.cnt_b", 32'(b_cnt), 32'd3);
        tick();
        check("sat.issue", 32'(a_ovalid), 32'd1);

        // I-type whose low immediate bits equal the tracked Rd: no hazard.
        Instr = {5'd17, 9'd1, 18'd9};
        settle();
        check("imm.ready", 32'(a_ready), 32'd1);
        tick();
        check_fields("imm", 1'b1, 5'd17, 9'd1, 9'd1, 9'd0, 20'd9);

        // No valid input: bubble.
        InValid = 1'b0;
        tick();
        check("idle.ovalid", 32'(a_ovalid), 32'd0);

        // Reset during STALL aborts it and empties the tracker.
        InValid = 1'b1;
        Instr = {5'd20, 9'd9, 18'd0};
        tick();
        tick();
        check("rs.cnt_a", 32'(a_cnt), 32'd5);
        rst = 1'b0;
        settle();
        check("rs.ready", 32'(a_ready), 32'd0);
        tick();
        check_fields("rs", 1'b0, 5'd0, 9'd0, 9'd0, 9'd0, 20'd0);
        check("rs.cnt_a0", 32'(a_cnt), 32'd0);
        check("rs.cnt_b0", 32'(b_cnt), 32'd0);
        rst = 1'b1;
        Instr = {5'd3, 9'd1, 9'd9, 9'd9};
        settle();
        check("rs.after_ready", 32'(a_ready), 32'd1);
        tick();
        check_fields("rs.after", 1'b1, 5'd3, 9'd1, 9'd9, 9'd9, 20'd0);
        check("rs.after_cnt", 32'(a_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter LOAD_OP, default 5'd20, opcode of the load instruction that creates a load-use hazard.
REQ-002 Parameter CNT_W, default 16, width of the stall counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 Instr  input  32  instruction word from fetch stage.
REQ-006 InValid  input  1  Instr valid this cycle.
REQ-007 InReady  output  1  combinational; stage accepts Instr this cycle.
REQ-008 Flush  input  1  branch-taken kill from EX; discards decode output.
REQ-009 OutValid  output  1  registered; decoded fields valid for ID/EX register.
REQ-010 OpCode  output  5  registered decoded opcode.
REQ-011 Rd, Rs, Rt  output  9 each  registered register indices.
REQ-012 Rsi  output  20  registered sign-extended immediate.
REQ-013 StallCount  output  CNT_W  registered count of inserted load-use bubbles.

Function
REQ-014 Field split: op=Instr[31:27], f1=Instr[26:18], f2=Instr[17:9], f3=Instr[8:0].
REQ-015 R-type (op[4]=0): Rd=f1, Rs=f2, Rt=f3, Rsi=0.
REQ-016 I-type (op[4]=1): Rd=f1, Rs=f1, Rt=0, Rsi=Instr[17:0] sign-extended to 20 bits (bit 17 replicated into bits 19:18).
REQ-017 Tracker: LdValid (1 bit) and LdRd (9 bits) record the destination of the instruction issued in the previous cycle when that instruction was LOAD_OP.
REQ-018 Hazard = state RUN and InValid and LdValid and LdRd!=0 and (Rs_dec==LdRd or (R-type and Rt_dec==LdRd)); register index 0 never hazards.
REQ-019 States: RUN, STALL; reset state RUN.
REQ-020 InReady = rst and not Flush and not Hazard; in STALL InReady=1 unless Flush.
REQ-021 Latency: accepted instruction appears on outputs with OutValid=1 one cycle after acceptance (edge where InValid and InReady are both 1).
REQ-022 RUN, Hazard: outputs bubble (OutValid=0, all fields 0), LdValid<=0, StallCount+1, state<=STALL; Instr not consumed.
REQ-023 STALL: fetch holds Instr with InValid=1; stage accepts it, issues it, updates tracker, state<=RUN.
REQ-024 Accept without hazard: issue decoded fields, OutValid<=1, LdValid<=(op==LOAD_OP), LdRd<=f1.
REQ-025 No valid input (InValid=0): bubble issued, LdValid<=0, state unchanged except STALL->RUN.
REQ-026 Flush=1 has priority over all: bubble issued, LdValid<=0, state<=RUN, StallCount unchanged, Instr not consumed.
REQ-027 StallCount saturates at all-ones; no wrap.
REQ-028 Back-to-back loads to same Rd: second load hazards on first only if it reads that Rd (I-type Rs=f1 does).

Reset
REQ-029 rst=0 at a rising edge: OutValid=0, OpCode=0, Rd=Rs=Rt=0, Rsi=0, StallCount=0, LdValid=0, LdRd=0, state RUN; overrides Flush and any in-flight stall.
REQ-030 InReady=0 while rst=0.
REQ-031 Reset asserted during STALL aborts the stall; first cycle after release is RUN with empty tracker.

Verification
REQ-032 R-type Instr={5'd3,9'd1,9'd2,9'd3}, InValid=1 -> next cycle OutValid=1, OpCode=3, Rd=1, Rs=2, Rt=3, Rsi=0.
REQ-033 I-type op=5'd17, f1=9'd6, imm=18'h3FFF0 -> OpCode=17, Rd=6, Rs=6, Rt=0, Rsi=20'hFFFF0.
REQ-034 LOAD (op 20, Rd=9) then R-type Rs=9 -> InReady=0 one cycle, one bubble (OutValid=0), StallCount=1, R-type issued next cycle.
REQ-035 LOAD to Rd=0 then R-type Rs=0 -> no stall, StallCount stays 0.
REQ-036 Flush=1 during STALL -> bubble, state RUN, tracker cleared, held Instr reissued without second stall.
REQ-037 Preload StallCount to all-ones via repeated hazards (CNT_W=2 build) -> fourth hazard leaves StallCount=2'b11; rst=0 mid-stream -> all outputs 0 next edge.
